// File: rtl/lstm_pkg.sv
// rtl/lstm_pkg.sv - shared types and elaboration helpers for the LSTM datapath blocks
package lstm_pkg;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, OUT} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int p = 1; p < v; p = p * 2) r = r + 1;
        return r;
    endfunction

    // The accumulator must hold LEN full-width products without wrapping.
    function automatic bit acc_w_legal(input int acc_w, input int data_w, input int len);
        return acc_w >= 2 * data_w + clog2(len);
    endfunction

endpackage

// File: rtl/lstm_sat_shift.sv
// rtl/lstm_sat_shift.sv - arithmetic right shift then signed saturation to OUT_W bits
module lstm_sat_shift
    import lstm_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int OUT_W = 8,
    parameter int FRAC  = 4
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [OUT_W-1:0] out_data,
    output logic                    out_sat
);

    logic signed [ACC_W-1:0] shifted;
    logic                    fits;

    assign shifted = acc >>> FRAC;

    // In range exactly when every bit above the result's sign bit copies it.
    assign fits = (&shifted[ACC_W-1:OUT_W-1]) | ~(|shifted[ACC_W-1:OUT_W-1]);

    always_comb begin
        out_sat  = ~fits;
        out_data = shifted[OUT_W-1:0];
        if (!fits) begin
            out_data = shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/lstm_dot_engine.sv
// rtl/lstm_dot_engine.sv - streams one weight row and the state vector from RAM, emits saturated dot product
module lstm_dot_engine
    import lstm_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int W_ADDR_W = 8,
    parameter int LEN      = 16,
    parameter int FRAC     = 4,
    parameter int ACC_W    = 24,
    parameter int OUT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [W_ADDR_W-1:0] w_base,
    output logic                busy,
    output logic [W_ADDR_W-1:0] w_rd_addr,
    output logic                w_rd_en,
    input  logic [DATA_W-1:0]   w_rd_data,
    output logic [ADDR_W-1:0]   x_rd_addr,
    output logic                x_rd_en,
    input  logic [DATA_W-1:0]   x_rd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_sat
);

    localparam int PW = 2 * DATA_W;
    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(LEN - 1);

    if (!acc_w_legal(ACC_W, DATA_W, LEN) || LEN < 1 || LEN > 2**ADDR_W) begin : g_bad_param
        $error("lstm_dot_engine: illegal ACC_W/LEN/ADDR_W combination");
    end

    state_t                  state;
    logic [ADDR_W-1:0]       k;
    logic [W_ADDR_W-1:0]     wb;
    logic                    rd_vld;
    logic                    prod_vld;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [DATA_W-1:0] w_s;
    logic signed [DATA_W-1:0] x_s;
    logic [OUT_W-1:0]        sat_data;
    logic                    sat_flag;

    assign w_s  = w_rd_data;
    assign x_s  = x_rd_data;
    assign busy = (state != IDLE);

    lstm_sat_shift #(.ACC_W(ACC_W), .OUT_W(OUT_W), .FRAC(FRAC)) u_sat (
        .acc      (acc),
        .out_data (sat_data),
        .out_sat  (sat_flag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            wb        <= '0;
            rd_vld    <= 1'b0;
            prod_vld  <= 1'b0;
            prod      <= '0;
            acc       <= '0;
            w_rd_addr <= '0;
            w_rd_en   <= 1'b0;
            x_rd_addr <= '0;
            x_rd_en   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            rd_vld   <= w_rd_en;
            prod_vld <= rd_vld;
            if (rd_vld) prod <= PW'(w_s) * PW'(x_s);
            if (prod_vld) acc <= acc + {{(ACC_W-PW){prod[PW-1]}}, prod};

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= READ;
                        wb        <= w_base;
                        k         <= '0;
                        acc       <= '0;
                        w_rd_en   <= 1'b1;
                        x_rd_en   <= 1'b1;
                        w_rd_addr <= w_base;
                        x_rd_addr <= '0;
                    end
                end
                READ: begin
                    // Addresses keep their last value once the final read is issued.
                    if (k == K_LAST) begin
                        w_rd_en <= 1'b0;
                        x_rd_en <= 1'b0;
                        state   <= DRAIN;
                    end else begin
                        k         <= k + ADDR_W'(1);
                        w_rd_addr <= wb + W_ADDR_W'(k) + W_ADDR_W'(1);
                        x_rd_addr <= k + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (!rd_vld && !prod_vld) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        out_data  <= sat_data;
                        out_sat   <= sat_flag;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_dot_engine.sv
// tb/tb_lstm_dot_engine.sv - scoreboard bench for lstm_dot_engine with a behavioural RAM and dot-product model
module tb_lstm_dot_engine;

    localparam int LEN = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] w_base = '0;
    logic       busy;
    logic [7:0] w_rd_addr;
    logic       w_rd_en;
    logic [7:0] w_rd_data;
    logic [3:0] x_rd_addr;
    logic       x_rd_en;
    logic [7:0] x_rd_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_sat;

    always #5 clk = ~clk;

    lstm_dot_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .w_base    (w_base),
        .busy      (busy),
        .w_rd_addr (w_rd_addr),
        .w_rd_en   (w_rd_en),
        .w_rd_data (w_rd_data),
        .x_rd_addr (x_rd_addr),
        .x_rd_en   (x_rd_en),
        .x_rd_data (x_rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    logic [7:0] wmem [256];
    logic [7:0] xmem [16];

    always @(posedge clk) begin
        if (w_rd_en) w_rd_data <= wmem[w_rd_addr];
        if (x_rd_en) x_rd_data <= xmem[x_rd_addr];
    end

    int applied = 0;
    int miscmp  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    typedef struct {
        int d;
        int s;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   waq[$];
    int   xaq[$];

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                mon_e = expq.pop_front();
                chk("out_data", $signed(out_data), mon_e.d);
                chk("out_sat", out_sat, mon_e.s);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && w_rd_en) begin
            waq.push_back(int'(w_rd_addr));
            xaq.push_back(int'(x_rd_addr));
        end
        if (!rst && (w_rd_en !== x_rd_en)) chk("enable_pair", x_rd_en, w_rd_en);
    end

    function automatic void model(input int wb, output int d, output int s);
        longint sum;
        longint q;
        sum = 0;
        for (int i = 0; i < LEN; i++)
            sum += longint'($signed(wmem[(wb + i) % 256])) * longint'($signed(xmem[i]));
        q = sum / 16;
        if ((sum % 16 != 0) && (sum < 0)) q = q - 1;
        if (q > 127) begin
            d = 127; s = 1;
        end else if (q < -128) begin
            d = -128; s = 1;
        end else begin
            d = int'(q); s = 0;
        end
    endfunction

    task automatic push_exp(input int d, input int s);
        exp_t e;
        e.d = d;
        e.s = s;
        expq.push_back(e);
    endtask

    task automatic fill(input int wv, input int xv);
        for (int i = 0; i < 256; i++) wmem[i] = 8'(wv);
        for (int i = 0; i < 16; i++) xmem[i] = 8'(xv);
    endtask

    task automatic launch(input int wb);
        w_base = 8'(wb);
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic finish_job(output int lat, output int done, input bit rand_ready);
        lat  = -1;
        done = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (lat < 0 && out_valid) lat = n;
            if (!busy) begin
                done = n;
                break;
            end
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
        if (done < 0) chk("job_timeout", 0, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_w_rd_en"}, w_rd_en, 0);
        chk({tag, "_x_rd_en"}, x_rd_en, 0);
        chk({tag, "_w_rd_addr"}, w_rd_addr, 0);
        chk({tag, "_x_rd_addr"}, x_rd_addr, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_sat"}, out_sat, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, done, d, s, wb;
        fill(1, 16);
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        out_ready = 1'b1;
        push_exp(16, 0);
        launch(0);
        finish_job(lat, done, 1'b0);
        chk("t1_latency", lat, 19);
        chk("t1_done", done, 20);

        fill(-128, 127);
        push_exp(-128, 1);
        launch(0);
        finish_job(lat, done, 1'b0);
        fill(127, 127);
        push_exp(127, 1);
        launch(3);
        finish_job(lat, done, 1'b0);

        for (int i = 0; i < 256; i++) wmem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) xmem[i] = 8'($urandom);
        model(250, d, s);
        push_exp(d, s);
        waq.delete();
        xaq.delete();
        launch(250);
        finish_job(lat, done, 1'b0);
        chk("t3_enable_cycles", waq.size(), 16);
        for (int i = 0; i < 16 && i < waq.size(); i++) begin
            chk("t3_w_rd_addr", waq[i], (250 + i) % 256);
            chk("t3_x_rd_addr", xaq[i], i);
        end
        chk("t3_w_addr_hold", w_rd_addr, 9);
        chk("t3_x_addr_hold", x_rd_addr, 15);

        fill(2, 16);
        out_ready = 1'b0;
        push_exp(32, 0);
        launch(0);
        for (int n = 0; n < 40 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        chk("t4_reach_out", out_valid, 1);
        for (int c = 0; c < 5; c++) begin
            start = (c == 1);
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_data", $signed(out_data), 32);
            chk("t4_hold_busy", busy, 1);
            @(posedge clk); #1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_valid_drop", out_valid, 0);
        chk("t4_idle", busy, 0);
        @(posedge clk); #1;
        chk("t4_start_ignored", w_rd_en, 0);

        fill(1, 16);
        launch(0);
        repeat (7) begin
            @(posedge clk); #1;
        end
        chk("t5_in_read", w_rd_en, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("t5_abort");
        rst = 1'b0;
        push_exp(16, 0);
        launch(0);
        finish_job(lat, done, 1'b0);
        chk("t5_latency", lat, 19);

        push_exp(16, 0);
        launch(0);
        finish_job(lat, done, 1'b0);
        chk("t6_period_a", done + 1, 21);
        fill(-3, 0);
        xmem[0] = 8'd1;
        push_exp(-1, 0);
        launch(0);
        finish_job(lat, done, 1'b0);
        chk("t6_latency_b", lat, 19);
        chk("t6_period_b", done + 1, 21);

        for (int j = 0; j < 20; j++) begin
            for (int i = 0; i < 256; i++) wmem[i] = 8'($urandom);
            for (int i = 0; i < 16; i++)
                xmem[i] = (j % 4 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            wb = $urandom_range(0, 255);
            model(wb, d, s);
            push_exp(d, s);
            launch(wb);
            finish_job(lat, done, 1'b1);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end

        chk("scoreboard_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscmp);
        $finish;
    end

endmodule
